aq_rtu_dtu_halt_ctrl: RTL
=========================

Name: aq_rtu_dtu_halt_ctrl

Overview:
- Retire-side responder to the debug trigger unit.
- Merges per-instruction trigger halt info carried by IFU/LSU into one retire-stage vector and presents it to the DTU.
- Answers the DTU's pending-halt request with pending/halt acknowledges, and drives debug-mode status (dbgon) with a latched cause.
- Sits in RTU between the retire stage and the DTU trigger block.

Parameters:
- HINFO_W, 22, width of trigger halt-info vector (one bit per trigger hit)
- CAUSE_W, 4, width of debug cause
- FLUSH_MAX, 255, max cycles allowed in FLUSH before timeout flag (8-bit counter)

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- retire_vld  in  1  instruction retires this cycle
- retire_mret  in  1  retiring instruction is mret
- retire_sret  in  1  retiring instruction is sret
- retire_expt_vld  in  1  exception/interrupt taken at retire boundary
- ifu_retire_halt_info  in  HINFO_W  IFU trigger hits carried with retiring instruction
- lsu_retire_halt_info  in  HINFO_W  LSU trigger hits carried with retiring instruction
- pipe_empty  in  1  no instruction in flight after retire
- dtu_pending_halt  in  1  DTU requests debug entry
- dtu_cause  in  CAUSE_W  DTU debug cause, valid while dtu_pending_halt
- had_resume  in  1  debug module resume pulse
- rtu_dtu_retire_vld  out  1  registered retire_vld
- rtu_dtu_retire_mret  out  1  registered retire_mret
- rtu_dtu_retire_sret  out  1  registered retire_sret
- rtu_dtu_retire_halt_info  out  HINFO_W  registered merged halt info
- rtu_dtu_pending_ack  out  1  one-cycle pulse: pending halt accepted at boundary
- rtu_dtu_halt_ack  out  1  one-cycle pulse: core halted
- rtu_ifu_flush  out  1  flush front end, high in FLUSH
- rtu_yy_xx_dbgon  out  1  core in debug mode
- rtu_had_dbg_cause  out  CAUSE_W  cause latched at pending_ack
- halt_timeout  out  1  sticky: FLUSH exceeded FLUSH_MAX

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- Retire path, 1-cycle latency:
  - rtu_dtu_retire_vld/mret/sret <= their inputs.
  - rtu_dtu_retire_halt_info <= retire_vld ? (ifu | lsu info) : 0.
  - Info with retire_vld=0 is ignored.
- FSM states IDLE, WAIT_BND, FLUSH, DEBUG, EXIT:
  - IDLE: dtu_pending_halt=1 and dbgon=0 -> WAIT_BND.
  - WAIT_BND: boundary = retire_vld | retire_expt_vld | pipe_empty.
    - On boundary with dtu_pending_halt=1: pulse pending_ack, latch dtu_cause into rtu_had_dbg_cause, clear counter -> FLUSH.
    - dtu_pending_halt drops before boundary -> IDLE with no ack.
  - FLUSH: rtu_ifu_flush=1; counter increments (saturates at 255).
    - pipe_empty=1 -> pulse halt_ack, set dbgon -> DEBUG.
    - Counter reaching FLUSH_MAX sets halt_timeout; FSM stays in FLUSH.
  - DEBUG: dbgon=1; dtu_pending_halt ignored; had_resume=1 -> EXIT.
  - EXIT: clears dbgon and counter for one cycle -> IDLE. A new pending halt is only recognised from IDLE.
- Simultaneous events:
  - In WAIT_BND, exception and retire in the same cycle are one boundary; a single ack is issued.
  - pipe_empty already high on the cycle FLUSH is entered gives halt_ack on the next cycle (minimum latency pending_ack -> halt_ack = 1 cycle).
  - had_resume outside DEBUG is ignored.
- Acks are never asserted in the same cycle, and never while dbgon=1 except the halt_ack cycle (dbgon rises the cycle after halt_ack).
- halt_timeout clears only on reset.
- Reset mid-operation: asynchronous return to IDLE; all outputs 0 immediately.

Test Plan:
- Reset: hold cpurst_b=0 in FLUSH -> all outputs 0 asynchronously; IDLE after release.
- Retire merge: retire_vld=1, ifu=0x000001, lsu=0x200000 -> next cycle rtu_dtu_retire_halt_info=0x200001, rtu_dtu_retire_vld=1. With retire_vld=0 and same info -> 0x000000.
- Normal halt: dtu_pending_halt=1, cause=4'h2, retire_vld at cycle 3, pipe_empty at cycle 6 ->
  - pending_ack pulse at cycle 3; rtu_had_dbg_cause=2.
  - halt_ack pulse at cycle 6; dbgon=1 from cycle 7.
  - had_resume -> dbgon=0 two cycles later.
- Withdrawn request: dtu_pending_halt high 2 cycles with no boundary, then low -> no acks; FSM back to IDLE.
- Exception boundary: pending halt plus retire_expt_vld=1 and retire_vld=1 in the same cycle -> exactly one pending_ack.
- Timeout: pipe_empty held 0 for 300 cycles in FLUSH -> halt_timeout=1 after 255 cycles, stays 1; counter saturates. Then pipe_empty=1 -> halt_ack.

Source files
------------

// File: rtl/aq_rtu_dtu_halt_ctrl_if.sv
// Retire-stage / DTU halt-handshake bundle between the RTU and the debug trigger unit.
// master drives retire info and DTU requests; slave is the RTU halt controller.
interface aq_rtu_dtu_halt_ctrl_if #(
  parameter int HINFO_W = 22,
  parameter int CAUSE_W = 4
);
  logic               retire_vld;
  logic               retire_mret;
  logic               retire_sret;
  logic               retire_expt_vld;
  logic [HINFO_W-1:0] ifu_retire_halt_info;
  logic [HINFO_W-1:0] lsu_retire_halt_info;
  logic               pipe_empty;
  logic               dtu_pending_halt;
  logic [CAUSE_W-1:0] dtu_cause;
  logic               had_resume;

  logic               rtu_dtu_retire_vld;
  logic               rtu_dtu_retire_mret;
  logic               rtu_dtu_retire_sret;
  logic [HINFO_W-1:0] rtu_dtu_retire_halt_info;
  logic               rtu_dtu_pending_ack;
  logic               rtu_dtu_halt_ack;
  logic               rtu_ifu_flush;
  logic               rtu_yy_xx_dbgon;
  logic [CAUSE_W-1:0] rtu_had_dbg_cause;
  logic               halt_timeout;

  modport master (
    output retire_vld, retire_mret, retire_sret, retire_expt_vld,
           ifu_retire_halt_info, lsu_retire_halt_info, pipe_empty,
           dtu_pending_halt, dtu_cause, had_resume,
    input  rtu_dtu_retire_vld, rtu_dtu_retire_mret, rtu_dtu_retire_sret,
           rtu_dtu_retire_halt_info, rtu_dtu_pending_ack, rtu_dtu_halt_ack,
           rtu_ifu_flush, rtu_yy_xx_dbgon, rtu_had_dbg_cause, halt_timeout
  );

  modport slave (
    input  retire_vld, retire_mret, retire_sret, retire_expt_vld,
           ifu_retire_halt_info, lsu_retire_halt_info, pipe_empty,
           dtu_pending_halt, dtu_cause, had_resume,
    output rtu_dtu_retire_vld, rtu_dtu_retire_mret, rtu_dtu_retire_sret,
           rtu_dtu_retire_halt_info, rtu_dtu_pending_ack, rtu_dtu_halt_ack,
           rtu_ifu_flush, rtu_yy_xx_dbgon, rtu_had_dbg_cause, halt_timeout
  );
endinterface

// File: rtl/aq_rtu_dtu_halt_ctrl.sv
// Retire-side DTU responder: 1-cycle registered retire/halt-info path, halt FSM with same-cycle acks.
// No backpressure: the DTU holds dtu_pending_halt until acked or withdrawn; acks are single-cycle pulses.
module aq_rtu_dtu_halt_ctrl #(
  parameter int HINFO_W   = 22,
  parameter int CAUSE_W   = 4,
  parameter int FLUSH_MAX = 255
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst_b,
  aq_rtu_dtu_halt_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BND = 3'd1,
    FLUSH    = 3'd2,
    DEBUG    = 3'd3,
    EXIT     = 3'd4
  } state_e;

  localparam logic [7:0] CNT_SAT  = 8'hff;
  localparam logic [7:0] CNT_LIM  = 8'(FLUSH_MAX);

  state_e             state_q;
  state_e             state_nxt;
  logic               pending_ack;
  logic               halt_ack;
  logic               boundary;
  logic [7:0]         flush_cnt_q;
  logic [7:0]         flush_cnt_inc;
  logic               dbgon_q;
  logic               timeout_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               retire_vld_q;
  logic               retire_mret_q;
  logic               retire_sret_q;
  logic [HINFO_W-1:0] halt_info_q;

  assign boundary      = bus.retire_vld | bus.retire_expt_vld | bus.pipe_empty;
  assign flush_cnt_inc = (flush_cnt_q == CNT_SAT) ? flush_cnt_q : flush_cnt_q + 8'd1;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    pending_ack = 1'b0;
    halt_ack    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dtu_pending_halt && !dbgon_q) begin
          state_nxt = WAIT_BND;
        end
      end
      WAIT_BND: begin
        if (!bus.dtu_pending_halt) begin
          state_nxt = IDLE;
        end else if (boundary) begin
          pending_ack = 1'b1;
          state_nxt   = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.pipe_empty) begin
          halt_ack  = 1'b1;
          state_nxt = DEBUG;
        end
      end
      DEBUG: begin
        if (bus.had_resume) begin
          state_nxt = EXIT;
        end
      end
      EXIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Flush-duration counter: restarts at each accepted request, saturates rather than wraps.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      flush_cnt_q <= 8'd0;
    end else if (pending_ack || (state_q == EXIT)) begin
      flush_cnt_q <= 8'd0;
    end else if (state_q == FLUSH) begin
      flush_cnt_q <= flush_cnt_inc;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      timeout_q <= 1'b0;
    end else if ((state_q == FLUSH) && (flush_cnt_inc == CNT_LIM)) begin
      timeout_q <= 1'b1;
    end
  end

  // dbgon trails halt_ack by one cycle and stays up through EXIT.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      dbgon_q <= 1'b0;
    end else if (halt_ack) begin
      dbgon_q <= 1'b1;
    end else if (state_q == EXIT) begin
      dbgon_q <= 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cause_q <= '0;
    end else if (pending_ack) begin
      cause_q <= bus.dtu_cause;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      retire_vld_q  <= 1'b0;
      retire_mret_q <= 1'b0;
      retire_sret_q <= 1'b0;
      halt_info_q   <= '0;
    end else begin
      retire_vld_q  <= bus.retire_vld;
      retire_mret_q <= bus.retire_mret;
      retire_sret_q <= bus.retire_sret;
      halt_info_q   <= bus.retire_vld ?
                       (bus.ifu_retire_halt_info | bus.lsu_retire_halt_info) : '0;
    end
  end

  assign bus.rtu_dtu_retire_vld       = retire_vld_q;
  assign bus.rtu_dtu_retire_mret      = retire_mret_q;
  assign bus.rtu_dtu_retire_sret      = retire_sret_q;
  assign bus.rtu_dtu_retire_halt_info = halt_info_q;
  assign bus.rtu_dtu_pending_ack      = pending_ack;
  assign bus.rtu_dtu_halt_ack         = halt_ack;
  assign bus.rtu_ifu_flush            = (state_q == FLUSH);
  assign bus.rtu_yy_xx_dbgon          = dbgon_q;
  assign bus.rtu_had_dbg_cause        = cause_q;
  assign bus.halt_timeout             = timeout_q;

endmodule
